// File: rtl/pump_motor_guard_if.sv
// pump_motor_guard_if: pump requests, level sensors, fault clear and motor/status outputs
// of the pump motor guard, bundled for the tank controller (master) and the guard (slave).
interface pump_motor_guard_if #(
    parameter int SCW = 8
);
    logic           B1, B2, S1, S2, S3, S4, Clear;
    logic           M1, M2, Fault;
    logic [1:0]     FaultCode;
    logic [SCW-1:0] Starts1, Starts2;

    modport master (
        output B1, B2, S1, S2, S3, S4, Clear,
        input  M1, M2, Fault, FaultCode, Starts1, Starts2
    );

    modport slave (
        input  B1, B2, S1, S2, S3, S4, Clear,
        output M1, M2, Fault, FaultCode, Starts1, Starts2
    );
endinterface

// File: rtl/pump_motor_guard.sv
// pump_motor_guard: turns raw pump requests into motor drives with min on/off times,
// start staggering, a pump 2 dry-run interlock and a latched sensor-plausibility fault.
module pump_motor_guard #(
    parameter int MIN_ON  = 8,
    parameter int MIN_OFF = 6,
    parameter int STAGGER = 4,
    parameter int CW      = 8,
    parameter int SCW     = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    pump_motor_guard_if.slave bus
);
    typedef enum logic {OFF, RUN} pump_t;
    typedef enum logic {NORMAL, FAULT} guard_t;

    localparam logic [CW-1:0]  ON_LD   = CW'(MIN_ON - 1);
    localparam logic [CW-1:0]  OFF_LD  = CW'(MIN_OFF - 1);
    localparam logic [CW-1:0]  STAG_LD = CW'(STAGGER - 1);
    localparam logic [SCW-1:0] S_MAX   = '1;

    pump_t          r_st1, r_st2;
    guard_t         r_guard;
    logic [CW-1:0]  r_on1, r_on2, r_off1, r_off2, r_stag;
    logic [1:0]     r_code;
    logic [SCW-1:0] r_starts1, r_starts2;

    logic w_bad1, w_bad2, w_trip, w_clear, w_ok;
    logic w_start1, w_start2, w_stop1, w_stop2;

    function automatic logic [CW-1:0] dec(input logic [CW-1:0] x);
        return x - CW'(x != '0);
    endfunction

    assign w_bad1  = bus.S2 & ~bus.S1;
    assign w_bad2  = bus.S4 & ~bus.S3;
    assign w_trip  = (r_guard == NORMAL) && (w_bad1 || w_bad2);
    assign w_clear = (r_guard == FAULT) && bus.Clear && !w_bad1 && !w_bad2;
    // A fault detected this cycle blocks any start in the same cycle
    assign w_ok    = (r_guard == NORMAL) && !w_bad1 && !w_bad2 && (r_stag == '0);

    assign w_start1 = (r_st1 == OFF) && bus.B1 && (r_off1 == '0) && w_ok;
    assign w_start2 = (r_st2 == OFF) && bus.B2 && bus.S1 && (r_off2 == '0) && w_ok && !w_start1;
    assign w_stop1  = (r_st1 == RUN) && ((!bus.B1 && r_on1 == '0) || w_trip);
    assign w_stop2  = (r_st2 == RUN) && ((!bus.B2 && r_on2 == '0) || !bus.S1 || w_trip);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_st1     <= OFF;
            r_st2     <= OFF;
            r_guard   <= NORMAL;
            r_on1     <= '0;
            r_on2     <= '0;
            r_off1    <= '0;
            r_off2    <= '0;
            r_stag    <= '0;
            r_code    <= '0;
            r_starts1 <= '0;
            r_starts2 <= '0;
        end else begin
            r_stag  <= (w_start1 || w_start2) ? STAG_LD : dec(r_stag);
            r_guard <= w_trip ? FAULT : (w_clear ? NORMAL : r_guard);
            r_code  <= w_clear ? 2'b00 : (r_code | {w_bad2, w_bad1});
            if (w_start1) begin
                r_st1     <= RUN;
                r_on1     <= ON_LD;
                r_starts1 <= r_starts1 + SCW'(r_starts1 != S_MAX);
            end else if (w_stop1) begin
                r_st1  <= OFF;
                r_off1 <= OFF_LD;
            end else begin
                r_on1  <= dec(r_on1);
                r_off1 <= w_clear ? OFF_LD : dec(r_off1);
            end
            if (w_start2) begin
                r_st2     <= RUN;
                r_on2     <= ON_LD;
                r_starts2 <= r_starts2 + SCW'(r_starts2 != S_MAX);
            end else if (w_stop2) begin
                r_st2  <= OFF;
                r_off2 <= OFF_LD;
            end else begin
                r_on2  <= dec(r_on2);
                r_off2 <= w_clear ? OFF_LD : dec(r_off2);
            end
        end
    end

    assign bus.M1        = (r_st1 == RUN);
    assign bus.M2        = (r_st2 == RUN);
    assign bus.Fault     = (r_guard == FAULT);
    assign bus.FaultCode = r_code;
    assign bus.Starts1   = r_starts1;
    assign bus.Starts2   = r_starts2;
endmodule

// File: tb/tb_pump_motor_guard.sv
// tb_pump_motor_guard: cycle-by-cycle vector table for timing, staggering, interlock and
// fault handling, plus hand sequences for asynchronous reset and start-counter saturation.
module tb_pump_motor_guard;
    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    pump_motor_guard_if #(.SCW(8)) bus ();

    pump_motor_guard #(
        .MIN_ON(8), .MIN_OFF(6), .STAGGER(4), .CW(8), .SCW(8)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    // in = {B1,B2,S1,S2,S3,S4,Clear}; ex = {M1,M2,Fault,FaultCode}
    typedef struct packed {
        logic [6:0] in;
        int         n;
        logic [4:0] ex;
        logic [7:0] st1;
        logic [7:0] st2;
    } vec_t;

    vec_t tbl [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] in);
        {bus.B1, bus.B2, bus.S1, bus.S2, bus.S3, bus.S4, bus.Clear} = in;
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.M1, bus.M2, bus.Fault, bus.FaultCode, bus.Starts1, bus.Starts2});
    endfunction

    task automatic wait_m1(input logic val, input string name);
        logic seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(posedge Clock);
            #1;
            seen = (bus.M1 === val);
        end
        if (!seen) check(name, 32'(bus.M1), 32'(val));
    endtask

    initial begin
        tbl[0]  = '{7'b1010100, 1, 5'b10000, 8'd1, 8'd0};
        tbl[1]  = '{7'b1010100, 1, 5'b10000, 8'd1, 8'd0};
        tbl[2]  = '{7'b0010100, 6, 5'b10000, 8'd1, 8'd0};
        tbl[3]  = '{7'b0010100, 1, 5'b00000, 8'd1, 8'd0};
        tbl[4]  = '{7'b1010100, 5, 5'b00000, 8'd1, 8'd0};
        tbl[5]  = '{7'b1010100, 1, 5'b10000, 8'd2, 8'd0};
        tbl[6]  = '{7'b0010100, 7, 5'b10000, 8'd2, 8'd0};
        tbl[7]  = '{7'b0010100, 1, 5'b00000, 8'd2, 8'd0};
        tbl[8]  = '{7'b0010100, 5, 5'b00000, 8'd2, 8'd0};
        tbl[9]  = '{7'b1110100, 4, 5'b10000, 8'd3, 8'd0};
        tbl[10] = '{7'b1110100, 1, 5'b11000, 8'd3, 8'd1};
        tbl[11] = '{7'b1110100, 1, 5'b11000, 8'd3, 8'd1};
        tbl[12] = '{7'b1100100, 1, 5'b10000, 8'd3, 8'd1};
        tbl[13] = '{7'b1100100, 8, 5'b10000, 8'd3, 8'd1};
        tbl[14] = '{7'b1110100, 1, 5'b11000, 8'd3, 8'd2};
        tbl[15] = '{7'b1110010, 1, 5'b00110, 8'd3, 8'd2};
        tbl[16] = '{7'b1110011, 1, 5'b00110, 8'd3, 8'd2};
        tbl[17] = '{7'b1110100, 3, 5'b00110, 8'd3, 8'd2};
        tbl[18] = '{7'b1110101, 1, 5'b00000, 8'd3, 8'd2};
        tbl[19] = '{7'b1110100, 5, 5'b00000, 8'd3, 8'd2};
        tbl[20] = '{7'b1110100, 1, 5'b10000, 8'd4, 8'd2};
        tbl[21] = '{7'b1110100, 3, 5'b10000, 8'd4, 8'd2};
        tbl[22] = '{7'b1110100, 1, 5'b11000, 8'd4, 8'd3};
        tbl[23] = '{7'b1110101, 1, 5'b11000, 8'd4, 8'd3};
        tbl[24] = '{7'b1101100, 1, 5'b00101, 8'd4, 8'd3};
        tbl[25] = '{7'b1100010, 1, 5'b00111, 8'd4, 8'd3};
        tbl[26] = '{7'b1110101, 1, 5'b00000, 8'd4, 8'd3};

        drive(7'b0010100);
        repeat (3) @(posedge Clock);
        #1;
        check("reset_state", outs(), 32'h0);
        Reset = 1'b1;

        for (int i = 0; i < 27; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                drive(tbl[i].in);
                @(posedge Clock);
                #1;
                check($sformatf("row%0d_cyc%0d", i, k), outs(),
                      32'({tbl[i].ex, tbl[i].st1, tbl[i].st2}));
            end
        end

        drive(7'b1010100);
        repeat (8) @(posedge Clock);
        #1;
        check("m1_before_async_reset", 32'(bus.M1), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset", outs(), 32'h0);

        drive(7'b0010100);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        for (int s = 1; s <= 300; s++) begin
            bus.B1 = 1'b1;
            wait_m1(1'b1, $sformatf("sat_rise_timeout_%0d", s));
            bus.B1 = 1'b0;
            wait_m1(1'b0, $sformatf("sat_fall_timeout_%0d", s));
            if (s == 254) check("starts1_254", 32'(bus.Starts1), 32'd254);
            if (s == 255) check("starts1_255", 32'(bus.Starts1), 32'd255);
        end
        check("starts1_saturated", 32'(bus.Starts1), 32'd255);
        check("starts2_idle", 32'(bus.Starts2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pump_motor_guard.md
Name: pump_motor_guard

Overview:
- Downstream stage of the two-tank water pump controller.
- Consumes the raw pump requests B1 (well to tank 1) and B2 (tank 1 to tank 2), together with the level sensors S1..S4, and produces the motor drive lines M1/M2.
- Enforces minimum on/off times and start staggering to limit inrush current.
- Provides a dry-run interlock for pump 2 and a latched sensor-plausibility fault, plus per-pump start counters.

Parameters:
MIN_ON, 8, minimum motor-on time in clock cycles (>=1)
MIN_OFF, 6, minimum motor-off time in clock cycles (>=1)
STAGGER, 4, minimum cycles between any two motor starts (>=1)
CW, 8, width of timer counters; MIN_ON, MIN_OFF, STAGGER must be < 2^CW
SCW, 8, width of start counters

Ports:
Clock  in  1  system clock, rising-edge
Reset  in  1  asynchronous, active-low reset
B1  in  1  pump 1 run request from tank controller
B2  in  1  pump 2 run request from tank controller
S1  in  1  tank 1 low-level sensor
S2  in  1  tank 1 high-level sensor
S3  in  1  tank 2 low-level sensor
S4  in  1  tank 2 high-level sensor
Clear  in  1  fault clear strobe, sampled on Clock
M1  out  1  pump 1 motor drive (registered)
M2  out  1  pump 2 motor drive (registered)
Fault  out  1  latched fault flag (registered)
FaultCode  out  2  bit0 = tank 1 inconsistency, bit1 = tank 2 inconsistency (latched)
Starts1  out  SCW  saturating count of pump 1 starts
Starts2  out  SCW  saturating count of pump 2 starts

Behaviour:
- Reset low, asynchronous: M1=M2=0, Fault=0, FaultCode=0, Starts1=Starts2=0, all timers 0, both pump FSMs in OFF, guard FSM in NORMAL. Pumps are therefore start-eligible on the first edge after release.
- All inputs are sampled on the rising edge. Outputs change only at edges, so there is one cycle of latency from request to motor.
- Per-pump FSM, one instance per pump: OFF, RUN.
  - OFF to RUN when all hold: req=1, off_cnt==0, stag_cnt==0, guard NORMAL, not lost on arbitration. Pump 2 additionally requires S1=1.
  - On entry to RUN: on_cnt<=MIN_ON-1, stag_cnt<=STAGGER-1, Starts+=1 (saturates at 2^SCW-1).
  - RUN: on_cnt decrements toward 0. RUN to OFF when req=0 and on_cnt==0; on exit, off_cnt<=MIN_OFF-1.
  - OFF: off_cnt decrements toward 0.
  - Net effect: each run lasts at least MIN_ON cycles, each off period lasts at least MIN_OFF cycles, and successive starts are at least STAGGER cycles apart.
- Arbitration: if both pumps are eligible in the same cycle, pump 1 starts and pump 2 waits for stag_cnt==0.
- Dry-run interlock: pump 2 in RUN with S1=0 goes to OFF at the next edge, overriding MIN_ON. off_cnt is loaded as normal. No fault is raised.
- Plausibility: bad1 = S2 & ~S1; bad2 = S4 & ~S3.
- Guard FSM: NORMAL, FAULT.
  - NORMAL to FAULT when bad1|bad2. At that edge: Fault<=1, FaultCode<=FaultCode|{bad2,bad1}, both pumps forced to OFF regardless of on_cnt, off_cnt<=MIN_OFF-1 for any pump that was in RUN.
  - In FAULT: no starts; FaultCode keeps OR-ing in new bad bits; off timers keep counting.
  - FAULT to NORMAL only when Clear=1 and bad1=bad2=0 in the same cycle. At that edge: Fault<=0, FaultCode<=0, both off_cnt<=MIN_OFF-1.
  - Clear while any bad bit is set is ignored.
  - Clear in NORMAL has no effect.
- Simultaneous fault and start eligibility in the same cycle: the fault wins and no start occurs.
- Start counters hold at the maximum value; they are never cleared except by Reset.

Test Plan:
Defaults for all cases: MIN_ON=8, MIN_OFF=6, STAGGER=4.
1. Release Reset, B1=1 for 2 cycles then 0, S1=1 -> M1=1 after edge 1, stays high exactly 8 cycles, Starts1=1.
2. After M1 falls, B1=1 continuously -> M1 low for exactly 6 cycles, then high; Starts1=2.
3. B1 and B2 rise in the same cycle, S1=1 -> M1 rises at edge 1, M2 rises at edge 5; B2 with S1=0 -> M2 never rises.
4. M2 running 2 cycles, S1 drops to 0 -> M2=0 at next edge, Fault stays 0.
5. Both motors running, drive S4=1,S3=0 -> both motors off at next edge, Fault=1, FaultCode=2'b10; Clear while S3=0 -> no change; set S3=1 then pulse Clear -> Fault=0, FaultCode=0, motors held off 6 cycles, then restart staggered by 4 cycles.
6. Assert Reset mid-run -> M1, M2, Fault and Starts go to 0 immediately without a clock edge; 300 start cycles on pump 1 -> Starts1 saturates at 255.
